// File: rtl/sub_bytes_lp_pipe_pkg.sv
// sub_bytes_lp_pipe_pkg: AES S-box tables and shared widths for the SubBytes pipe
package sub_bytes_lp_pipe_pkg;
    localparam int BYTE_W     = 8;
    localparam int MAX_NBYTES = 16;
    localparam logic [BYTE_W-1:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [BYTE_W-1:0] SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
endpackage

// File: rtl/sub_bytes_lp_pipe_if.sv
// sub_bytes_lp_pipe_if: valid/ready input and output streams of the SubBytes pipe
interface sub_bytes_lp_pipe_if #(parameter int NBYTES = 4);
    import sub_bytes_lp_pipe_pkg::*;
    logic                     in_valid, in_ready, inv_mode, out_valid, out_ready;
    logic [BYTE_W*NBYTES-1:0] in_data, out_data;
    logic [NBYTES-1:0]        lane_mask;
    modport master (output in_valid, inv_mode, in_data, lane_mask, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, inv_mode, in_data, lane_mask, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/sub_bytes_lp_pipe_sbox_lane.sv
// sbox_lane: one byte lane of forward/inverse S-box lookup with operand-isolated bypass
module sbox_lane
    import sub_bytes_lp_pipe_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    input  logic              inv,
    input  logic              en,
    output logic [BYTE_W-1:0] sub
);
    logic [BYTE_W-1:0] idx, look;
    // disabled lanes present a constant index so the tables never toggle, and pass their byte through
    always_comb begin
        idx  = en ? data : '0;
        look = inv ? SBOX_INV[idx] : SBOX_FWD[idx];
        sub  = en ? look : data;
    end
endmodule

// File: rtl/sub_bytes_lp_pipe.sv
// sub_bytes_lp_pipe: pipelined multi-lane AES SubBytes/InvSubBytes with valid/ready and enable freeze
module sub_bytes_lp_pipe
    import sub_bytes_lp_pipe_pkg::*;
#(
    parameter int NBYTES  = 4,
    parameter bit OUT_REG = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    sub_bytes_lp_pipe_if.slave   bus,
    output logic                 busy
);
    localparam int W = BYTE_W*NBYTES;
    logic [W-1:0]      s1_data, sub;
    logic [NBYTES-1:0] s1_mask;
    logic              s1_mode, v1, v2, s1_adv, accept;
    genvar k;
    for (k = 0; k < NBYTES; k++) begin : g_lane
        sbox_lane u_lane (.data(s1_data[BYTE_W*k +: BYTE_W]), .inv(s1_mode), .en(s1_mask[k]), .sub(sub[BYTE_W*k +: BYTE_W]));
    end
    // without an output register the input stage is the output stage, so a downstream take must always retire it
    assign s1_adv       = v1 & (OUT_REG ? enable & (!v2 | bus.out_ready) : bus.out_ready);
    assign bus.in_ready = rst_n & enable & (!v1 | s1_adv);
    assign accept       = bus.in_valid & bus.in_ready;
    assign busy         = v1 | v2;
    // input stage: capture beat with its mask and mode on accept, retire on advance, otherwise hold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_data <= '0;
            s1_mask <= '0;
            s1_mode <= 1'b0;
            v1      <= 1'b0;
        end else if (accept) begin
            s1_data <= bus.in_data;
            s1_mask <= bus.lane_mask;
            s1_mode <= bus.inv_mode;
            v1      <= 1'b1;
        end else if (s1_adv) v1 <= 1'b0;
    if (OUT_REG) begin : g_out
        logic [W-1:0] s2_data;
        // output stage: load substituted beat on advance, drop valid once taken and not refilled
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                s2_data <= '0;
                v2      <= 1'b0;
            end else if (s1_adv) begin
                s2_data <= sub;
                v2      <= 1'b1;
            end else if (bus.out_ready) v2 <= 1'b0;
        assign bus.out_valid = v2;
        assign bus.out_data  = s2_data;
    end else begin : g_out
        assign v2            = 1'b0;
        assign bus.out_valid = v1;
        assign bus.out_data  = sub;
    end
endmodule
